slot_spin_ctrl: RTL



---
 rtl/slot_pkg.sv | 39 +++
 rtl/slot_score_eval.sv | 48 ++++
 rtl/slot_spin_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/slot_pkg.sv
// ---------------------------------------------------------------------------
// slot_pkg
//   Shared types and constants for the slot reel sequencer.
//   - state_t     : spin lifecycle IDLE -> SPIN -> STOP -> SHOW
//   - NUM_REELS   : number of reels on the display
//   - DIGIT_MAX   : highest displayable digit
//   - SCORE_*     : score values produced for the landed digits
//   - next_digit  : one roll step (counts down, 0 wraps to 9)
//   - fold_digit  : maps a raw 4-bit RNG value onto 0..9
// ---------------------------------------------------------------------------
package slot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    STOP = 2'd2,
    SHOW = 2'd3
  } state_t;

  localparam int unsigned NUM_REELS = 4;

  localparam logic [3:0] DIGIT_MAX   = 4'd9;
  localparam logic [3:0] SCORE_ALL   = 4'd10;
  localparam logic [3:0] SCORE_THREE = 4'd5;
  localparam logic [3:0] SCORE_PAIR  = 4'd1;
  localparam logic [3:0] SCORE_NONE  = 4'd0;

  // Reels roll downwards; 0 wraps back to the top digit.
  function automatic logic [3:0] next_digit(input logic [3:0] d);
    return (d == 4'd0) ? DIGIT_MAX : d - 4'd1;
  endfunction

  // The RNG delivers 0..15; 10..15 fold onto 0..5 so a target is
  // always a digit the reel can actually reach.
  function automatic logic [3:0] fold_digit(input logic [3:0] d);
    return (d > DIGIT_MAX) ? d - 4'd10 : d;
  endfunction

endpackage

// File: rtl/slot_score_eval.sv
// ---------------------------------------------------------------------------
// slot_score_eval
//   Purely combinational scoring of the four landed digits.
//   Ports:
//     d0..d3 : landed digit of reel 0..3
//     score  : SCORE_ALL   when all four digits match
//              SCORE_THREE when any three digits match
//              SCORE_PAIR  when any two digits match
//              SCORE_NONE  otherwise
// ---------------------------------------------------------------------------
module slot_score_eval
  import slot_pkg::*;
(
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [3:0] score
);

  logic e01, e02, e03, e12, e13, e23;
  logic all_eq, three_eq, pair_eq;

  always_comb begin
    e01 = (d0 == d1);
    e02 = (d0 == d2);
    e03 = (d0 == d3);
    e12 = (d1 == d2);
    e13 = (d1 == d3);
    e23 = (d2 == d3);

    all_eq   = e01 & e12 & e23;
    // One term per choice of three reels out of four.
    three_eq = (e01 & e12) | (e01 & e13) | (e02 & e23) | (e12 & e23);
    pair_eq  = e01 | e02 | e03 | e12 | e13 | e23;

    if (all_eq) begin
      score = SCORE_ALL;
    end else if (three_eq) begin
      score = SCORE_THREE;
    end else if (pair_eq) begin
      score = SCORE_PAIR;
    end else begin
      score = SCORE_NONE;
    end
  end

endmodule

// File: rtl/slot_spin_ctrl.sv
// ---------------------------------------------------------------------------
// slot_spin_ctrl
//   Spin sequencer for the four-reel slot display. Owns the rolling reel
//   counters and the IDLE -> SPIN -> STOP -> SHOW lifecycle. A spin press
//   rolls all reels for SPIN_CYCLES, captures the RNG targets, lands the
//   reels on their targets one at a time in reel order, then holds the
//   result and its score for SHOW_CYCLES.
//
//   Parameters:
//     STEP_CYCLES : clk cycles per reel step
//     SPIN_CYCLES : clk cycles spent in SPIN
//     SHOW_CYCLES : clk cycles spent in SHOW
//
//   Ports:
//     clk          : system clock
//     rst          : synchronous active-high reset
//     spin         : spin button level, already synchronised to clk
//     tgt0..tgt3   : RNG target digits (raw 0..15) for reels 0..3
//     reel0..reel3 : digit currently shown by each reel, 0..9
//     locked       : bit i set once reel i has landed
//     busy         : high in SPIN, STOP and SHOW
//     done         : one-cycle pulse on entry to SHOW
//     score        : registered score of the landed digits
//     score_valid  : high throughout SHOW
// ---------------------------------------------------------------------------
module slot_spin_ctrl
  import slot_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 70,
  parameter int unsigned SPIN_CYCLES = 1400,
  parameter int unsigned SHOW_CYCLES = 3500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spin,
  input  logic [3:0] tgt0,
  input  logic [3:0] tgt1,
  input  logic [3:0] tgt2,
  input  logic [3:0] tgt3,
  output logic [3:0] reel0,
  output logic [3:0] reel1,
  output logic [3:0] reel2,
  output logic [3:0] reel3,
  output logic [3:0] locked,
  output logic       busy,
  output logic       done,
  output logic [3:0] score,
  output logic       score_valid
);

  // Counter widths sized to the largest value each must hold.
  localparam int unsigned TIMER_MAX = (SPIN_CYCLES > SHOW_CYCLES) ? SPIN_CYCLES : SHOW_CYCLES;
  localparam int unsigned TW        = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam int unsigned SW        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t               state;
  logic [SW-1:0]        step_cnt;
  logic [TW-1:0]        timer;
  logic                 spin_q;
  logic [3:0]           reel_q [NUM_REELS];
  logic [3:0]           tgt_q  [NUM_REELS];
  logic [NUM_REELS-1:0] locked_q;
  logic                 busy_q;
  logic                 done_q;
  logic [3:0]           score_q;
  logic                 score_valid_q;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic                 tick;
  logic                 spin_edge;
  logic                 rolling;
  logic [NUM_REELS-1:0] eligible;
  logic [NUM_REELS-1:0] step_en;
  logic [NUM_REELS-1:0] lock_set;
  logic [3:0]           eval_score;

  always_comb begin
    tick      = (step_cnt == SW'(STEP_CYCLES - 1));
    spin_edge = spin & ~spin_q;
    rolling   = (state == IDLE) || (state == SPIN) || (state == STOP);

    // Reel 0 is always eligible; every later reel waits for the registered
    // lock of its predecessor. Only the lowest unlocked reel can therefore
    // be eligible, which limits landing to one reel per tick.
    eligible  = {locked_q[NUM_REELS-2:0], 1'b1};

    step_en   = '0;
    lock_set  = '0;
    if (tick && rolling) begin
      for (int unsigned i = 0; i < NUM_REELS; i++) begin
        if (!locked_q[i]) begin
          if ((state == STOP) && eligible[i] && (reel_q[i] == tgt_q[i])) begin
            lock_set[i] = 1'b1;
          end else begin
            step_en[i] = 1'b1;
          end
        end
      end
    end
  end

  slot_score_eval u_score_eval (
    .d0    (reel_q[0]),
    .d1    (reel_q[1]),
    .d2    (reel_q[2]),
    .d3    (reel_q[3]),
    .score (eval_score)
  );

  // -------------------------------------------------------------------------
  // Sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      step_cnt      <= '0;
      timer         <= '0;
      spin_q        <= 1'b0;
      locked_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      score_q       <= '0;
      score_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REELS; i++) begin
        reel_q[i] <= DIGIT_MAX;
        tgt_q[i]  <= '0;
      end
    end else begin
      spin_q <= spin;
      done_q <= 1'b0;

      // Free-running step divider, independent of the lifecycle state.
      step_cnt <= tick ? '0 : step_cnt + 1'b1;

      for (int unsigned i = 0; i < NUM_REELS; i++) begin
        if (step_en[i]) begin
          reel_q[i] <= next_digit(reel_q[i]);
        end
      end

      locked_q <= locked_q | lock_set;

      unique case (state)
        IDLE: begin
          if (spin_edge) begin
            state  <= SPIN;
            timer  <= TW'(SPIN_CYCLES - 1);
            busy_q <= 1'b1;
          end
        end

        SPIN: begin
          if (timer == '0) begin
            state    <= STOP;
            tgt_q[0] <= fold_digit(tgt0);
            tgt_q[1] <= fold_digit(tgt1);
            tgt_q[2] <= fold_digit(tgt2);
            tgt_q[3] <= fold_digit(tgt3);
          end else begin
            timer <= timer - 1'b1;
          end
        end

        STOP: begin
          if (locked_q == '1) begin
            state         <= SHOW;
            score_q       <= eval_score;
            done_q        <= 1'b1;
            score_valid_q <= 1'b1;
            timer         <= TW'(SHOW_CYCLES - 1);
          end
        end

        SHOW: begin
          if (timer == '0) begin
            state         <= IDLE;
            locked_q      <= '0;
            busy_q        <= 1'b0;
            score_valid_q <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign reel0       = reel_q[0];
  assign reel1       = reel_q[1];
  assign reel2       = reel_q[2];
  assign reel3       = reel_q[3];
  assign locked      = locked_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign score       = score_q;
  assign score_valid = score_valid_q;

endmodule
